bp_table_ctrl: RTL and testbench

BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

---
 rtl/bp_table_ctrl.sv | 119 +++++++++++
 tb/tb_bp_table_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_ctrl.sv
// Branch predictor table controller: after reset/flush it sweeps every entry to INIT_CNT,
// then applies resolved branch updates queued in a 2-entry FIFO, one table write per cycle.
module bp_table_ctrl #(
    parameter int unsigned IDX_W    = 11,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_req_i,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    input  logic [1:0]       tbl_cnt_i,
    output logic [IDX_W-1:0] tbl_idx_o,
    output logic             tbl_cnt_we_o,
    output logic [1:0]       tbl_cnt_o,
    output logic             tbl_tgt_we_o,
    output logic [31:0]      tbl_tgt_o,
    output logic             busy_o
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] init_cnt_q;

    logic [IDX_W-1:0] fifo_idx_q [2];
    logic [31:0]      fifo_tgt_q [2];
    logic             fifo_tkn_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic [31:0]      head_tgt;
    logic             head_tkn;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_tgt   = fifo_tgt_q[rd_ptr_q];
    assign head_tkn   = fifo_tkn_q[rd_ptr_q];

    // Update handshake: a transfer happens on a posedge where upd_valid_i && upd_ready_o.
    // Ready reflects FIFO fullness before any same-cycle pop, is low during flush/reset,
    // and never depends on upd_valid_i.
    assign upd_ready_o = !fifo_full && !flush_req_i && !rst_i;
    assign push        = upd_valid_i && upd_ready_o;
    assign pop         = (state_q == ST_RUN) && !fifo_empty && !flush_req_i && !rst_i;
    assign busy_o      = rst_i || (state_q == ST_INIT);

    always_comb begin
        tbl_idx_o    = '0;
        tbl_cnt_we_o = 1'b0;
        tbl_cnt_o    = '0;
        tbl_tgt_we_o = 1'b0;
        tbl_tgt_o    = '0;
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                tbl_idx_o    = init_cnt_q;
                tbl_cnt_we_o = 1'b1;
                tbl_cnt_o    = INIT_CNT;
                tbl_tgt_we_o = 1'b1;
            end else if (pop) begin
                tbl_idx_o    = head_idx;
                tbl_cnt_we_o = 1'b1;
                // Two-bit saturating counter
                if (head_tkn) begin
                    tbl_cnt_o = (tbl_cnt_i == 2'b11) ? 2'b11 : tbl_cnt_i + 2'b01;
                end else begin
                    tbl_cnt_o = (tbl_cnt_i == 2'b00) ? 2'b00 : tbl_cnt_i - 2'b01;
                end
                tbl_tgt_we_o = head_tkn;
                tbl_tgt_o    = head_tkn ? head_tgt : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_req_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + IDX_W'(1);
                if (init_cnt_q == '1) begin
                    state_q <= ST_RUN;
                end
            end
            if (push) begin
                fifo_idx_q[wr_ptr_q] <= upd_idx_i;
                fifo_tgt_q[wr_ptr_q] <= upd_target_i;
                fifo_tkn_q[wr_ptr_q] <= upd_taken_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl (IDX_W = 4): a reference model predicts every table write,
// and a negedge monitor compares observed writes against the expected queue.
module tb_bp_table_ctrl;

    localparam int IDX_W = 4;
    localparam int DEPTH = 16;
    localparam int W     = 40;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_req_i;
    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic [31:0]      upd_target_i;
    logic             upd_taken_i;
    logic             upd_ready_o;
    logic [1:0]       tbl_cnt_i;
    logic [IDX_W-1:0] tbl_idx_o;
    logic             tbl_cnt_we_o;
    logic [1:0]       tbl_cnt_o;
    logic             tbl_tgt_we_o;
    logic [31:0]      tbl_tgt_o;
    logic             busy_o;

    always #5 clk_i = ~clk_i;

    bp_table_ctrl #(.IDX_W(IDX_W), .INIT_CNT(2'b01)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_req_i  (flush_req_i),
        .upd_valid_i  (upd_valid_i),
        .upd_idx_i    (upd_idx_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i),
        .upd_ready_o  (upd_ready_o),
        .tbl_cnt_i    (tbl_cnt_i),
        .tbl_idx_o    (tbl_idx_o),
        .tbl_cnt_we_o (tbl_cnt_we_o),
        .tbl_cnt_o    (tbl_cnt_o),
        .tbl_tgt_we_o (tbl_tgt_we_o),
        .tbl_tgt_o    (tbl_tgt_o),
        .busy_o       (busy_o)
    );

    // The counter array the controller drives: synchronous write, combinational read.
    logic [1:0] mem_cnt [DEPTH];
    assign tbl_cnt_i = mem_cnt[tbl_idx_o];
    always @(posedge clk_i) begin
        if (tbl_cnt_we_o) mem_cnt[tbl_idx_o] <= tbl_cnt_o;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   m_cnt [DEPTH];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected write = {idx, cnt_we, cnt, tgt_we, tgt}
    task automatic model_sweep();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_cnt[i] = 2'b01;
            exp_q.push_back({4'(i), 1'b1, 2'b01, 1'b1, 32'h0});
        end
    endtask

    task automatic model_accept(input logic [3:0] ix, input logic [31:0] tg, input logic tk);
        int c;
        int n;
        c = int'(m_cnt[ix]);
        if (tk) n = (c == 3) ? 3 : c + 1;
        else    n = (c == 0) ? 0 : c - 1;
        m_cnt[ix] = 2'(n);
        exp_q.push_back({ix, 1'b1, 2'(n), tk, tk ? tg : 32'h0});
    endtask

    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("reset_gating", {37'h0, tbl_cnt_we_o, tbl_tgt_we_o, upd_ready_o}, 40'h0);
        end else if (tbl_cnt_we_o || tbl_tgt_we_o) begin
            mon_act = {tbl_idx_o, tbl_cnt_we_o, tbl_cnt_o, tbl_tgt_we_o,
                       tbl_tgt_we_o ? tbl_tgt_o : 32'h0};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got %h expected no write", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("table_write", mon_act, mon_exp);
            end
        end else if (busy_o == 1'b0) begin
            check("idle_outputs", {2'b0, tbl_idx_o, tbl_cnt_o, tbl_tgt_o}, 40'h0);
        end
    end

    logic       rdy_s;
    logic       we_s;
    logic       bsy_s;
    logic [3:0] ix_s;

    // One clock cycle: entered and left at posedge+1; DUT sampled at the negedge between.
    task automatic drive_cycle(input logic v, input logic [3:0] ix, input logic [31:0] tg,
                               input logic tk, input logic fl, input logic rs);
        if (rs || fl) model_sweep();
        rst_i        = rs;
        flush_req_i  = fl;
        upd_valid_i  = v;
        upd_idx_i    = ix;
        upd_target_i = tg;
        upd_taken_i  = tk;
        @(negedge clk_i);
        rdy_s = upd_ready_o;
        we_s  = tbl_cnt_we_o;
        bsy_s = busy_o;
        ix_s  = tbl_idx_o;
        @(posedge clk_i);
        if (v && rdy_s) model_accept(ix, tg, tk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i        = 1'b1;
        flush_req_i  = 1'b0;
        upd_valid_i  = 1'b0;
        upd_idx_i    = '0;
        upd_target_i = '0;
        upd_taken_i  = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset then full init sweep
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_ready", {39'h0, rdy_s}, 40'h0);
        check("rst_busy", {39'h0, bsy_s}, 40'h1);
        for (int i = 0; i < DEPTH; i++) begin
            idle_cycle();
            check("init_busy", {39'h0, bsy_s}, 40'h1);
            check("init_idx", {36'h0, ix_s}, 40'(i));
        end
        idle_cycle();
        check("run_busy", {39'h0, bsy_s}, 40'h0);
        check("run_idle_we", {39'h0, we_s}, 40'h0);

        // Single update latency, then saturation and back-to-back same-index updates
        drive_cycle(1'b1, 4'd5, 32'h100, 1'b1, 1'b0, 1'b0);
        check("upd_ready_run", {39'h0, rdy_s}, 40'h1);
        idle_cycle();
        check("latency_we", {39'h0, we_s}, 40'h1);
        drive_cycle(1'b1, 4'd5, 32'h104, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd5, 32'h108, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd7, 32'h200, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd7, 32'h204, 1'b0, 1'b0, 1'b0);
        repeat (3) idle_cycle();

        // Three pushes during init: third stalls, two drain in the first RUN cycles
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 4'd2, 32'h222, 1'b1, 1'b0, 1'b0);
        check("init_push0_ready", {39'h0, rdy_s}, 40'h1);
        drive_cycle(1'b1, 4'd3, 32'h333, 1'b0, 1'b0, 1'b0);
        check("init_push1_ready", {39'h0, rdy_s}, 40'h1);
        drive_cycle(1'b1, 4'd4, 32'h444, 1'b1, 1'b0, 1'b0);
        check("full_stall_ready", {39'h0, rdy_s}, 40'h0);
        for (int i = 0; i < 30; i++) begin
            idle_cycle();
            if (!bsy_s) break;
        end
        check("first_run_busy", {39'h0, bsy_s}, 40'h0);
        check("first_run_we", {39'h0, we_s}, 40'h1);
        idle_cycle();
        check("second_run_we", {39'h0, we_s}, 40'h1);
        idle_cycle();
        check("third_run_we", {39'h0, we_s}, 40'h0);

        // Flush in RUN with two queued entries
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 4'd9, 32'h900, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd10, 32'hA00, 1'b1, 1'b0, 1'b0);
        repeat (14) idle_cycle();
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("flush_cycle_busy", {39'h0, bsy_s}, 40'h0);
        check("flush_cycle_we", {39'h0, we_s}, 40'h0);
        idle_cycle();
        check("post_flush_busy", {39'h0, bsy_s}, 40'h1);
        check("post_flush_idx", {36'h0, ix_s}, 40'h0);
        repeat (16) idle_cycle();

        // Reset mid-init at idx 9 with one pending update
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 4'd3, 32'h300, 1'b1, 1'b0, 1'b0);
        repeat (8) idle_cycle();
        check("pre_rst_idx", {36'h0, ix_s}, 40'h8);
        drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_we", {39'h0, we_s}, 40'h0);
        idle_cycle();
        check("post_rst_idx", {36'h0, ix_s}, 40'h0);
        check("post_rst_we", {39'h0, we_s}, 40'h1);
        repeat (16) idle_cycle();
        check("post_rst_fifo_empty", {39'h0, we_s}, 40'h0);

        // Randomized traffic with occasional flushes in RUN
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        $urandom, 1'($urandom_range(0, 1)),
                        (!busy_o && $urandom_range(0, 60) == 0), 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            idle_cycle();
        end
        check("drain", 40'(exp_q.size()), 40'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
